md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Multiply/divide scheduler and HI/LO owner for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E, using the already-forwarded rs/rt operands.
- Models a multi-cycle MD resource with a busy counter, and commits results to HI/LO after a fixed latency.
- Drives the stall request consumed by the hazard unit, so D-stage MD instructions wait while the resource is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- E_MDOp  input  4  MD operation of the instruction in E: NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- E_A  input  32  forwarded rs value.
- E_B  input  32  forwarded rt value.
- D_IsMD  input  1  the instruction in D is any MD-class op.
- E_Flush  input  1  the E-stage instruction is a bubble; suppresses start and HI/LO writes.
- md_busy  output  1  MD resource occupied.
- md_stall  output  1  stall request to the hazard unit.
- md_out  output  32  HI for MFHI, LO for MFLO, otherwise 0.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0.
  - HI=LO=0, pending HI/LO=0.
  - md_busy=0.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE, MUL, DIV.
- start = (E_MDOp in {MULT,MULTU,DIV,DIVU}) & !E_Flush & state==IDLE.
- IDLE, start seen at edge k:
  - Pending {HI,LO} is latched from the md_arith result of E_A/E_B.
  - cnt is loaded with MULT_CYCLES or DIV_CYCLES.
  - state goes to MUL or DIV.
  - md_busy=1 for cycles k+1 .. k+N.
- MUL/DIV:
  - cnt decrements each edge.
  - At the edge where cnt==1: HI/LO take the pending values, state returns to IDLE, cnt=0.
  - md_busy=0 in the cycle after that edge.
- md_busy = (state!=IDLE).
- md_stall = D_IsMD & (md_busy | start). This is combinational and covers the start cycle itself.
- MTHI/MTLO (when !E_Flush and state==IDLE):
  - Write E_A to HI or LO at the next edge, 1-cycle latency.
  - No busy period.
- MD op arriving in E while busy:
  - Cannot occur under a correct hazard unit.
  - RTL ignores it (no state change). Bench flags it as a protocol error.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = upper word, LO = lower word.
  - MULTU: the same, unsigned.
  - DIV: LO = quotient, HI = remainder. Signed, truncation toward zero; the remainder takes the sign of the dividend.
  - DIVU: the same, unsigned.
  - Divide by zero: the busy period still runs, but HI/LO are left unchanged at commit.
  - Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- md_out:
  - Combinational from the current HI/LO registers, selected by E_MDOp.
  - Only meaningful when !md_busy. The stall guarantees MFHI/MFLO never reach E during a busy period.
- No internal bypass from pending to md_out.
- Simultaneous commit edge and D_IsMD: md_stall drops in the cycle after commit, so the waiting MD op enters E with HI/LO already updated.

Decomposition:
- Shared package/header:
  - E_MDOp encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8).
  - State encodings (IDLE=0, MUL=1, DIV=2).
  - Default cycle counts.
- One sub-module, md_arith: purely combinational signed/unsigned mul/div producing {hi,lo}, including the divide-by-zero flag.
- md_sched holds only the FSM, counter, pending and HI/LO registers, and the stall logic.

Test Plan:
1. Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> md_busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
2. DIV A=-7, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 -> LO=3, HI=1.
3. MULT started with D_IsMD=1 (MFLO in D) -> md_stall=1 in the start cycle and for all 5 busy cycles, 0 in the next cycle; md_out=LO result when MFLO reaches E.
4. DIV with B=0 after MTHI 0x1234 and MTLO 0x5678 -> busy 10 cycles, HI=0x1234, LO=0x5678 unchanged. Also check MTHI/MTLO take 1 cycle with no busy.
5. reset=0 asynchronously in cycle 3 of a DIV -> md_busy, HI and LO are 0 immediately. After release, MFHI yields md_out=0, no late commit occurs, and the next MULT starts normally.
6. MULT with E_Flush=1 -> no busy period, HI/LO unchanged. MULT arriving while busy -> ignored and flagged by the bench.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared encodings and defaults for the multiply/divide scheduler.
package md_sched_pkg;

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMfhi  = 4'd7,
        OpMflo  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2
    } md_state_e;

    localparam int unsigned DefMultCycles = 5;
    localparam int unsigned DefDivCycles  = 10;

    // Ops that occupy the MD resource for a busy period.
    function automatic logic is_start_op(md_op_e op);
        return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide producing {hi, lo}.
module md_arith
    import md_sched_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic               div_ovf;

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'b0, a} * {32'b0, b};
    assign quot_s = $signed(a) / $signed(b);
    assign rem_s  = $signed(a) % $signed(b);

    // Most-negative / -1 overflows the quotient; pin it to the wrapped value.
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign div_zero = (b == 32'b0) && ((op == OpDiv) || (op == OpDivu));

    always_comb begin
        hi = '0;
        lo = '0;
        case (op)
            OpMult:  {hi, lo} = prod_s;
            OpMultu: {hi, lo} = prod_u;
            OpDiv: begin
                if (div_ovf) begin
                    lo = 32'h8000_0000;
                    hi = '0;
                end else if (!div_zero) begin
                    lo = quot_s;
                    hi = rem_s;
                end
            end
            OpDivu: begin
                if (!div_zero) begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// E-stage multiply/divide scheduler: owns HI/LO, models a fixed-latency MD unit, requests stalls.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefMultCycles,
    parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_IsMD,
    input  logic        E_Flush,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_op_e    op;
    md_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_dz_q, pend_dz_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] arith_hi, arith_lo;
    logic        arith_dz;
    logic        start;

    assign op    = md_op_e'(E_MDOp);
    assign start = is_start_op(op) && !E_Flush && (state_q == StIdle);

    md_arith u_arith (
        .op       (op),
        .a        (E_A),
        .b        (E_B),
        .hi       (arith_hi),
        .lo       (arith_lo),
        .div_zero (arith_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    pend_hi_d = arith_hi;
                    pend_lo_d = arith_lo;
                    pend_dz_d = arith_dz;
                    if ((op == OpMult) || (op == OpMultu)) begin
                        cnt_d   = 4'(MULT_CYCLES);
                        state_d = StMul;
                    end else begin
                        cnt_d   = 4'(DIV_CYCLES);
                        state_d = StDiv;
                    end
                end else if (!E_Flush) begin
                    if (op == OpMthi) hi_d = E_A;
                    if (op == OpMtlo) lo_d = E_A;
                end
            end
            StMul, StDiv: begin
                // MD ops arriving here are ignored; the hazard unit must hold them in D.
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy  = (state_q != StIdle);
    assign md_stall = D_IsMD && (md_busy || start);
    assign HI       = hi_q;
    assign LO       = lo_q;

    always_comb begin
        md_out = '0;
        case (op)
            OpMfhi:  md_out = hi_q;
            OpMflo:  md_out = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: directed scenarios plus randomized MD traffic.
module tb_md_sched;
    import md_sched_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic [31:0] E_A, E_B;
    logic        D_IsMD, E_Flush;
    logic        md_busy, md_stall;
    logic [31:0] md_out, HI, LO;

    always #5 clk = ~clk;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_MDOp   (E_MDOp),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_IsMD   (D_IsMD),
        .E_Flush  (E_Flush),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .md_out   (md_out),
        .HI       (HI),
        .LO       (LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          protocol_errs = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference arithmetic from the ISA rules: wide products, magnitude division with sign fix-up.
    task automatic ref_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, p, ma, mb, q, r;
        longint unsigned ua, ub, pu;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        hi = m_hi;
        lo = m_lo;
        dz = 1'b0;
        case (op)
            OpMult: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            OpMultu: begin
                pu = ua * ub;
                hi = pu[63:32];
                lo = pu[31:0];
            end
            OpDiv: begin
                if (b == 0) dz = 1'b1;
                else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    r  = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            OpDivu: begin
                if (b == 0) dz = 1'b1;
                else begin
                    lo = 32'(ua / ub);
                    hi = 32'(ua % ub);
                end
            end
            default: ;
        endcase
    endtask

    // Monitor: each busy period ending is a result presentation; compare to the scoreboard.
    int run_len = 0;
    always @(negedge clk) begin
        if (!reset) begin
            run_len = 0;
        end else if (md_busy === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_commit: got busy period of %0d cycles, required none",
                         run_len);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_busy_len"}, 32'(run_len), 32'(e.cycles));
                check({e.name, "_hi"}, HI, e.hi);
                check({e.name, "_lo"}, LO, e.lo);
            end
            run_len = 0;
        end
    end

    // One E-stage slot: drive at the falling edge, check stall/busy/md_out, release next cycle.
    task automatic issue(string name, md_op_e op, logic [31:0] a, logic [31:0] b,
                         logic flush, logic d_ismd);
        logic        m_busy, st, mt;
        logic [31:0] eh, el;
        logic        dz;
        exp_t        e;
        @(negedge clk);
        #1;
        m_busy = (sb_q.size() != 0);
        st     = is_start_op(op) && !flush && !m_busy;
        mt     = !flush && !m_busy && ((op == OpMthi) || (op == OpMtlo));
        if (is_start_op(op) && !flush && m_busy) begin
            protocol_errs++;
            $display("protocol error flagged: %s issued to E while MD busy", name);
        end
        E_MDOp  = op;
        E_A     = a;
        E_B     = b;
        E_Flush = flush;
        D_IsMD  = d_ismd;
        #1;
        check({name, "_busy_in"}, {31'b0, md_busy}, {31'b0, m_busy});
        check({name, "_stall"}, {31'b0, md_stall}, {31'b0, d_ismd & (m_busy | st)});
        if (!m_busy && op == OpMfhi) check({name, "_mfhi"}, md_out, m_hi);
        if (!m_busy && op == OpMflo) check({name, "_mflo"}, md_out, m_lo);
        if (st) begin
            ref_md(op, a, b, eh, el, dz);
            m_hi     = eh;
            m_lo     = el;
            e.hi     = eh;
            e.lo     = el;
            e.cycles = ((op == OpMult) || (op == OpMultu)) ? MC : DC;
            e.name   = name;
            sb_q.push_back(e);
        end
        if (mt && op == OpMthi) m_hi = a;
        if (mt && op == OpMtlo) m_lo = a;
        @(negedge clk);
        #1;
        E_MDOp  = OpNone;
        E_Flush = 1'b0;
        if (mt) begin
            check({name, "_mt_hi"}, HI, m_hi);
            check({name, "_mt_lo"}, LO, m_lo);
            check({name, "_mt_nobusy"}, {31'b0, md_busy}, 32'd0);
        end
    endtask

    task automatic wait_idle(string name);
        int k = 0;
        while ((sb_q.size() != 0 || md_busy !== 1'b0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        #2;
        if (k >= 40) begin
            n_checks++;
            $display("FAIL %s_timeout: got busy after 40 cycles, required idle", name);
        end
    endtask

    initial begin
        reset   = 1'b0;
        E_MDOp  = OpNone;
        E_A     = '0;
        E_B     = '0;
        D_IsMD  = 1'b0;
        E_Flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, md_busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        #2 reset = 1'b1;

        // Multiply, signed and unsigned
        issue("mult", OpMult, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        wait_idle("mult");
        check("mult_hi_const", HI, 32'hFFFF_FFFF);
        check("mult_lo_const", LO, 32'hFFFF_FFFA);
        issue("multu", OpMultu, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        wait_idle("multu");
        check("multu_hi_const", HI, 32'h0000_0002);

        // Divide, signed and unsigned
        issue("div", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        wait_idle("div");
        check("div_lo_const", LO, 32'hFFFF_FFFD);
        check("div_hi_const", HI, 32'hFFFF_FFFF);
        issue("divu", OpDivu, 32'd7, 32'd2, 1'b0, 1'b0);
        wait_idle("divu");

        // Stall covers the start cycle and every busy cycle, then drops
        issue("mult_stall", OpMult, 32'd1234, 32'd5678, 1'b0, 1'b1);
        for (int i = 0; i < int'(MC); i++) begin
            check("stall_busy_cycle", {31'b0, md_stall}, 32'd1);
            @(negedge clk);
            #2;
        end
        check("stall_after_commit", {31'b0, md_stall}, 32'd0);
        issue("mflo_after", OpMflo, 32'd0, 32'd0, 1'b0, 1'b0);
        check("mflo_after_const", LO, 32'd7006652);

        // Divide by zero leaves HI/LO alone
        issue("mthi", OpMthi, 32'h1234, 32'd0, 1'b0, 1'b0);
        issue("mtlo", OpMtlo, 32'h5678, 32'd0, 1'b0, 1'b0);
        issue("div0", OpDiv, 32'd99, 32'd0, 1'b0, 1'b0);
        wait_idle("div0");
        check("div0_hi_const", HI, 32'h1234);
        check("div0_lo_const", LO, 32'h5678);
        issue("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_idle("div_ovf");

        // Asynchronous reset mid-divide discards the result
        issue("div_rst", OpDiv, 32'd100, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'b0, md_busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        sb_q.delete();
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        issue("mfhi_rst", OpMfhi, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        #2;
        check("no_late_commit_hi", HI, 32'd0);
        check("no_late_commit_busy", {31'b0, md_busy}, 32'd0);
        issue("mult_post_rst", OpMult, 32'd6, 32'd7, 1'b0, 1'b0);
        wait_idle("mult_post_rst");

        // Flushed MULT does nothing; MULT while busy is ignored
        issue("mult_flush", OpMult, 32'd9, 32'd9, 1'b1, 1'b1);
        check("flush_nobusy", {31'b0, md_busy}, 32'd0);
        check("flush_lo", LO, 32'd42);
        issue("mthi_flush", OpMthi, 32'hDEAD, 32'd0, 1'b1, 1'b0);
        check("mthi_flush_hi", HI, m_hi);
        issue("div_proto", OpDiv, 32'hFFFF_FF9C, 32'd9, 1'b0, 1'b0);
        issue("mult_proto", OpMult, 32'd3, 32'd4, 1'b0, 1'b0);
        wait_idle("div_proto");
        check("protocol_flagged", 32'(protocol_errs), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            md_op_e      op;
            logic [31:0] a, b;
            int unsigned sel;
            op  = md_op_e'(4'($urandom_range(1, 8)));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (sel == 2) b = 32'($urandom_range(1, 7));
            issue("rnd", op, a, b, 1'b0, 1'($urandom_range(0, 1)));
            if (is_start_op(op)) wait_idle("rnd");
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
